csr_timer_controller: RTL and testbench

Sequencer and configuration block for the core's 64-bit CSR timer registers. It generates the per-cycle count enables for the cycle, instret and time counters, with per-counter inhibit and an optional time prescaler. It also holds a 64-bit compare value and runs the timer-interrupt state machine against the time counter's value. It sits in the CSR block beside the timer registers and shares the CSR read/write bus with them.

---
 rtl/csr_timer_controller_pkg.sv | 25 ++
 rtl/csr_timer_controller_if.sv | 24 ++
 rtl/timer_prescaler.sv | 42 ++++
 rtl/csr_timer_controller.sv | 144 ++++++++++++++
 tb/tb_csr_timer_controller.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/csr_timer_controller_pkg.sv
// Shared constants for the CSR timer controller: default CSR addresses, interrupt state
// encoding and control-register bit positions.
package csr_timer_controller_pkg;

  localparam logic [11:0] AddrCompareLower = 12'h7C0;
  localparam logic [11:0] AddrCompareUpper = 12'h7C1;
  localparam logic [11:0] AddrControl      = 12'h7C2;
  localparam logic [11:0] AddrPrescale     = 12'h7C3;

  localparam int unsigned PrescaleWidthDefault = 16;

  localparam int unsigned CtrlCycleInhibit   = 0;
  localparam int unsigned CtrlInstretInhibit = 1;
  localparam int unsigned CtrlTimeInhibit    = 2;
  localparam int unsigned CtrlIrqEnable      = 3;
  localparam int unsigned CtrlWidth          = 4;

  typedef enum logic [1:0] {
    StDisarmed  = 2'd0,
    StWaitUpper = 2'd1,
    StArmed     = 2'd2,
    StFired     = 2'd3
  } timer_state_e;

endpackage

// File: rtl/csr_timer_controller_if.sv
// CSR read/write bus shared by the timer registers and the timer controller.
interface csr_timer_controller_if;

    logic        csrWriteEnable;
    logic [11:0] csrWriteAddress;
    logic [31:0] csrWriteData;
    logic        csrReadEnable;
    logic [11:0] csrReadAddress;
    logic [31:0] csrReadData;
    logic        csrRequestOutput;

    modport master (
        output csrWriteEnable, csrWriteAddress, csrWriteData,
        output csrReadEnable, csrReadAddress,
        input  csrReadData, csrRequestOutput
    );

    modport slave (
        input  csrWriteEnable, csrWriteAddress, csrWriteData,
        input  csrReadEnable, csrReadAddress,
        output csrReadData, csrRequestOutput
    );

endinterface

// File: rtl/timer_prescaler.sv
// Time-counter prescaler: ticks when the counter equals the programmed value, then wraps.
// A load writes the prescale value and restarts the count from zero.
module timer_prescaler #(
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_i,
    input  logic [PRESCALE_WIDTH-1:0] load_value_i,
    input  logic                      enable_i,
    output logic                      tick_o,
    output logic [PRESCALE_WIDTH-1:0] prescale_o
);

    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] count_q, count_d;

    assign tick_o     = (count_q == prescale_q);
    assign prescale_o = prescale_q;

    always_comb begin
        prescale_d = prescale_q;
        count_d    = count_q;
        if (load_i) begin
            prescale_d = load_value_i;
            count_d    = '0;
        end else if (enable_i) begin
            count_d = tick_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q <= '0;
            count_q    <= '0;
        end else begin
            prescale_q <= prescale_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: rtl/csr_timer_controller.sv
// CSR timer controller: count enables for cycle/instret/time counters, 64-bit compare and
// timer-interrupt FSM. Optional time prescaler enabled by CSR_TIMER_PRESCALER_EN.
module csr_timer_controller
    import csr_timer_controller_pkg::*;
#(
    parameter logic [11:0] ADDRESS_COMPARE_LOWER = AddrCompareLower,
    parameter logic [11:0] ADDRESS_COMPARE_UPPER = AddrCompareUpper,
    parameter logic [11:0] ADDRESS_CONTROL       = AddrControl,
    parameter logic [11:0] ADDRESS_PRESCALE      = AddrPrescale,
    parameter int unsigned PRESCALE_WIDTH        = PrescaleWidthDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    csr_timer_controller_if.slave csr_bus,
    input  logic                  instructionRetired_i,
    input  logic [63:0]           timeValue_i,
    output logic                  cycleCount_o,
    output logic                  instretCount_o,
    output logic                  timeCount_o,
    output logic                  timerInterrupt_o
);

    logic [63:0]          compare_q, compare_d;
    logic [CtrlWidth-1:0] ctrl_q, ctrl_d;
    timer_state_e         state_q, state_d;
    logic                 irq_q, irq_d;

    logic wr_lower, wr_upper, wr_ctrl;
    logic time_tick;
    logic [31:0] prescale_rd;

    assign wr_lower = csr_bus.csrWriteEnable && (csr_bus.csrWriteAddress == ADDRESS_COMPARE_LOWER);
    assign wr_upper = csr_bus.csrWriteEnable && (csr_bus.csrWriteAddress == ADDRESS_COMPARE_UPPER);
    assign wr_ctrl  = csr_bus.csrWriteEnable && (csr_bus.csrWriteAddress == ADDRESS_CONTROL);

`ifdef CSR_TIMER_PRESCALER_EN
    logic                      wr_prescale;
    logic [PRESCALE_WIDTH-1:0] prescale_value;

    assign wr_prescale = csr_bus.csrWriteEnable && (csr_bus.csrWriteAddress == ADDRESS_PRESCALE);

    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk         (clk),
        .rst         (rst),
        .load_i      (wr_prescale),
        .load_value_i(csr_bus.csrWriteData[PRESCALE_WIDTH-1:0]),
        .enable_i    (!ctrl_q[CtrlTimeInhibit]),
        .tick_o      (time_tick),
        .prescale_o  (prescale_value)
    );

    assign prescale_rd = 32'(prescale_value);
`else
    logic unused_prescale_cfg;

    assign unused_prescale_cfg = ^{ADDRESS_PRESCALE, PRESCALE_WIDTH[0]};
    assign time_tick           = 1'b1;
    assign prescale_rd         = '0;
`endif

    assign cycleCount_o     = !ctrl_q[CtrlCycleInhibit];
    assign instretCount_o   = instructionRetired_i && !ctrl_q[CtrlInstretInhibit];
    assign timeCount_o      = time_tick && !ctrl_q[CtrlTimeInhibit];
    assign timerInterrupt_o = irq_q;

    always_comb begin
        compare_d = compare_q;
        ctrl_d    = ctrl_q;
        if (wr_lower) compare_d[31:0]  = csr_bus.csrWriteData;
        if (wr_upper) compare_d[63:32] = csr_bus.csrWriteData;
        if (wr_ctrl)  ctrl_d           = csr_bus.csrWriteData[CtrlWidth-1:0];
    end

    // Compare writes always win over the time match.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StDisarmed: begin
                if (wr_upper)      state_d = StArmed;
                else if (wr_lower) state_d = StWaitUpper;
            end
            StWaitUpper: begin
                if (wr_upper) state_d = StArmed;
            end
            StArmed: begin
                if (wr_lower)                       state_d = StWaitUpper;
                else if (wr_upper)                  state_d = StArmed;
                else if (timeValue_i >= compare_q)  state_d = StFired;
            end
            StFired: begin
                if (wr_lower)      state_d = StWaitUpper;
                else if (wr_upper) state_d = StArmed;
            end
            default: state_d = StDisarmed;
        endcase
        irq_d = (state_q == StFired) && ctrl_q[CtrlIrqEnable];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            compare_q <= '1;
            ctrl_q    <= '0;
            state_q   <= StDisarmed;
            irq_q     <= 1'b0;
        end else begin
            compare_q <= compare_d;
            ctrl_q    <= ctrl_d;
            state_q   <= state_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        csr_bus.csrReadData      = '0;
        csr_bus.csrRequestOutput = 1'b0;
        if (csr_bus.csrReadEnable) begin
            if (csr_bus.csrReadAddress == ADDRESS_COMPARE_LOWER) begin
                csr_bus.csrReadData      = compare_q[31:0];
                csr_bus.csrRequestOutput = 1'b1;
            end else if (csr_bus.csrReadAddress == ADDRESS_COMPARE_UPPER) begin
                csr_bus.csrReadData      = compare_q[63:32];
                csr_bus.csrRequestOutput = 1'b1;
            end else if (csr_bus.csrReadAddress == ADDRESS_CONTROL) begin
                csr_bus.csrReadData      = {26'd0, state_q, ctrl_q};
                csr_bus.csrRequestOutput = 1'b1;
            end
`ifdef CSR_TIMER_PRESCALER_EN
            else if (csr_bus.csrReadAddress == ADDRESS_PRESCALE) begin
                csr_bus.csrReadData      = prescale_rd;
                csr_bus.csrRequestOutput = 1'b1;
            end
`endif
        end
    end

`ifndef CSR_TIMER_PRESCALER_EN
    logic unused_prescale_rd;

    assign unused_prescale_rd = ^prescale_rd;
`endif

endmodule

// File: tb/tb_csr_timer_controller.sv
// Directed self-checking bench for csr_timer_controller; prescaler checks follow
// CSR_TIMER_PRESCALER_EN.
module tb_csr_timer_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_ret;
    logic [63:0] time_value;
    logic        cycle_count, instret_count, time_count, timer_irq;

    int tests_run = 0;
    int tests_failed = 0;

    csr_timer_controller_if bus ();

    csr_timer_controller dut (
        .clk                 (clk),
        .rst                 (rst),
        .csr_bus             (bus),
        .instructionRetired_i(instr_ret),
        .timeValue_i         (time_value),
        .cycleCount_o        (cycle_count),
        .instretCount_o      (instret_count),
        .timeCount_o         (time_count),
        .timerInterrupt_o    (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        bus.csrWriteEnable  = 1'b1;
        bus.csrWriteAddress = addr;
        bus.csrWriteData    = data;
        step();
        bus.csrWriteEnable  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [11:0] addr,
                              input logic [31:0] exp_data, input logic exp_req);
        bus.csrReadEnable  = 1'b1;
        bus.csrReadAddress = addr;
        #1;
        check_eq({tag, "_data"}, bus.csrReadData, exp_data);
        check_eq({tag, "_req"}, bus.csrRequestOutput, exp_req);
        bus.csrReadEnable  = 1'b0;
    endtask

    logic [7:0] pattern;

    initial begin
        rst                 = 1'b1;
        instr_ret           = 1'b1;
        time_value          = '0;
        bus.csrWriteEnable  = 1'b0;
        bus.csrWriteAddress = '0;
        bus.csrWriteData    = '0;
        bus.csrReadEnable   = 1'b0;
        bus.csrReadAddress  = '0;
        step();
        step();

        // Reset state
        check_eq("rst_irq", timer_irq, 1'b0);
        check_eq("rst_cycle", cycle_count, 1'b1);
        check_eq("rst_time", time_count, 1'b1);
        check_eq("rst_instret", instret_count, 1'b1);
        read_check("rst_ctrl", 12'h7C2, 32'h0, 1'b1);
        read_check("rst_cmp_lo", 12'h7C0, 32'hFFFF_FFFF, 1'b1);
        read_check("rst_cmp_hi", 12'h7C1, 32'hFFFF_FFFF, 1'b1);
`ifdef CSR_TIMER_PRESCALER_EN
        read_check("rst_presc", 12'h7C3, 32'h0, 1'b1);
`else
        read_check("rst_presc", 12'h7C3, 32'h0, 1'b0);
`endif
        rst = 1'b0;
        step();

        // Split compare write
        csr_write(12'h7C2, 32'h8);
        time_value = 64'h20;
        csr_write(12'h7C0, 32'h10);
        read_check("split_wait", 12'h7C2, 32'h18, 1'b1);
        step();
        step();
        read_check("split_nofire", 12'h7C2, 32'h18, 1'b1);
        check_eq("split_noirq", timer_irq, 1'b0);
        csr_write(12'h7C1, 32'h0);
        read_check("split_armed", 12'h7C2, 32'h28, 1'b1);
        step();
        read_check("split_fired", 12'h7C2, 32'h38, 1'b1);
        check_eq("split_irq_lat", timer_irq, 1'b0);
        step();
        check_eq("split_irq", timer_irq, 1'b1);

        // Match boundary
        time_value = 64'hFE;
        csr_write(12'h7C0, 32'h100);
        csr_write(12'h7C1, 32'h0);
        read_check("bnd_armed", 12'h7C2, 32'h28, 1'b1);
        check_eq("bnd_irq_off", timer_irq, 1'b0);
        step();
        read_check("bnd_fe", 12'h7C2, 32'h28, 1'b1);
        time_value = 64'hFF;
        step();
        read_check("bnd_ff", 12'h7C2, 32'h28, 1'b1);
        time_value = 64'h100;
        step();
        read_check("bnd_100", 12'h7C2, 32'h38, 1'b1);
        step();
        check_eq("bnd_irq", timer_irq, 1'b1);
        csr_write(12'h7C1, 32'h1);
        read_check("bnd_rearm", 12'h7C2, 32'h28, 1'b1);
        read_check("bnd_cmp_hi", 12'h7C1, 32'h1, 1'b1);
        step();
        check_eq("bnd_irq_drop", timer_irq, 1'b0);

        // Inhibit
        csr_write(12'h7C2, 32'h7);
        check_eq("inh_cycle", cycle_count, 1'b0);
        check_eq("inh_instret", instret_count, 1'b0);
        check_eq("inh_time", time_count, 1'b0);
        read_check("inh_ctrl", 12'h7C2, 32'h27, 1'b1);
        csr_write(12'h7C2, 32'hFFFF_FFF8);
        read_check("ctrl_ro_bits", 12'h7C2, 32'h28, 1'b1);
        csr_write(12'h7C2, 32'h0);
        check_eq("uninh_cycle", cycle_count, 1'b1);
        check_eq("uninh_instret", instret_count, 1'b1);
        check_eq("uninh_time", time_count, 1'b1);
        instr_ret = 1'b0;
        #1;
        check_eq("instret_follow", instret_count, 1'b0);

        // Prescaler
`ifdef CSR_TIMER_PRESCALER_EN
        csr_write(12'h7C3, 32'h3);
        read_check("presc_rd", 12'h7C3, 32'h3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            pattern[i] = time_count;
            step();
        end
        check_eq("presc_div4", pattern, 8'b1000_1000);
        step();
        csr_write(12'h7C3, 32'h0);
        for (int i = 0; i < 4; i++) begin
            pattern[i] = time_count;
            step();
        end
        check_eq("presc_div1", pattern[3:0], 4'b1111);
`else
        csr_write(12'h7C3, 32'h3);
        read_check("presc_unmapped", 12'h7C3, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pattern[i] = time_count;
            step();
        end
        check_eq("presc_off_tick", pattern[3:0], 4'b1111);
`endif

        // Unmapped address
        csr_write(12'h7C4, 32'hFFFF_FFFF);
        read_check("unmapped", 12'h7C4, 32'h0, 1'b0);
        read_check("unmapped_noeff", 12'h7C2, 32'h20, 1'b1);

        // Read/write collision on the same address returns the old value
        bus.csrWriteEnable  = 1'b1;
        bus.csrWriteAddress = 12'h7C0;
        bus.csrWriteData    = 32'h55;
        read_check("coll_old", 12'h7C0, 32'h100, 1'b1);
        step();
        bus.csrWriteEnable  = 1'b0;
        read_check("coll_new", 12'h7C0, 32'h55, 1'b1);

        // Reset while FIRED, with a concurrent control write
        time_value = 64'h100;
        csr_write(12'h7C2, 32'h8);
        csr_write(12'h7C1, 32'h0);
        step();
        step();
        check_eq("pre_rst_irq", timer_irq, 1'b1);
        rst = 1'b1;
        bus.csrWriteEnable  = 1'b1;
        bus.csrWriteAddress = 12'h7C2;
        bus.csrWriteData    = 32'hF;
        step();
        bus.csrWriteEnable  = 1'b0;
        check_eq("rst_fired_irq", timer_irq, 1'b0);
        read_check("rst_fired_ctrl", 12'h7C2, 32'h0, 1'b1);
        read_check("rst_fired_cmp", 12'h7C0, 32'hFFFF_FFFF, 1'b1);
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
